tia_line_timing_generator: RTL and testbench

// - Parametrised horizontal line timing for the TIA core; successor to the fixed LFSR/decoder/biphase chain.
// - Binary line counter with configurable line length and decode points.
// - Generates HSYNC/HBLANK/composite sync and blank, the WSYNC rdy handshake and the RSYNC line reset.
// - Adds HMOVE extended blank and a 4-clock-stepped motion comparison count; replaces the horizontal_timing, LFSR and divide-by-three instances.

---
 rtl/tia_line_timing_generator_pkg.sv | 27 ++
 rtl/tia_line_timing_generator_divide_by_n.sv | 35 +++
 rtl/tia_line_timing_generator.sv | 143 ++++++++++++++
 tb/tb_tia_line_timing_generator.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tia_line_timing_generator_pkg.sv
// Shared line-timing constants, widths and decode payload for the TIA horizontal timing block.
package tia_line_timing_generator_pkg;

    localparam int unsigned LINE_CLKS_DEF    = 228;
    localparam int unsigned HSYNC_START_DEF  = 20;
    localparam int unsigned HSYNC_END_DEF    = 36;
    localparam int unsigned HBLANK_END_DEF   = 68;
    localparam int unsigned HMOVE_EXT_DEF    = 8;
    localparam int unsigned MOTION_STEPS_DEF = 15;
    localparam int unsigned CPU_DIV_DEF      = 3;

    localparam int unsigned HMC_W     = 4;
    localparam int unsigned PHASE_W   = 2;
    localparam int unsigned SEC_LAST  = 3;

    // Per-clock decode of the current horizontal position.
    typedef struct packed {
        logic line_start;
        logic hsync;
        logic hblank;
    } line_dec_t;

    function automatic int unsigned hcount_width(input int unsigned line_clks);
        return (line_clks > 1) ? $clog2(line_clks) : 1;
    endfunction

endpackage

// File: rtl/tia_line_timing_generator_divide_by_n.sv
// Free-running clock divider producing the CPU phase clock; high for the first N/2 clocks of each period.
module tia_divide_by_n #(
    parameter int unsigned N = 3
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic out_o
);

    localparam int unsigned DW = (N > 1) ? $clog2(N) : 1;

    logic [DW-1:0] cnt_q, cnt_d;
    logic          out_q, out_d;

    always_comb begin
        cnt_d = cnt_q + DW'(1);
        if (cnt_q == DW'(N - 1)) begin
            cnt_d = '0;
        end
        out_d = (cnt_d < DW'(N / 2));
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out_o = out_q;

endmodule

// File: rtl/tia_line_timing_generator.sv
// Horizontal line timing for the TIA: line counter, sync/blank decodes, HMOVE sequencer,
// WSYNC ready latch and the CPU phase clock.
module tia_line_timing_generator
    import tia_line_timing_generator_pkg::*;
#(
    parameter int unsigned LINE_CLKS    = LINE_CLKS_DEF,
    parameter int unsigned HSYNC_START  = HSYNC_START_DEF,
    parameter int unsigned HSYNC_END    = HSYNC_END_DEF,
    parameter int unsigned HBLANK_END   = HBLANK_END_DEF,
    parameter int unsigned HMOVE_EXT    = HMOVE_EXT_DEF,
    parameter int unsigned MOTION_STEPS = MOTION_STEPS_DEF,
    parameter int unsigned CPU_DIV      = CPU_DIV_DEF,
    localparam int unsigned HCW         = hcount_width(LINE_CLKS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wsyn_i,
    input  logic             rsyn_i,
    input  logic             hmove_i,
    input  logic             vsyn_i,
    input  logic             vblk_i,
    output logic [HCW-1:0]   hcount_o,
    output logic             line_start_o,
    output logic             hsync_o,
    output logic             syn_o,
    output logic             blank_o,
    output logic             motck_en_o,
    output logic [HMC_W-1:0] hmove_count_o,
    output logic             sec_o,
    output logic             rdy_o,
    output logic             phi_theta_o
);

    // Decode limits carried one bit wider so an extended blank end may exceed the line range.
    localparam logic [HCW:0]   HSYNC_START_X = (HCW + 1)'(HSYNC_START);
    localparam logic [HCW:0]   HSYNC_END_X   = (HCW + 1)'(HSYNC_END);
    localparam logic [HCW:0]   BLANK_X       = (HCW + 1)'(HBLANK_END);
    localparam logic [HCW:0]   BLANK_EXT_X   = (HCW + 1)'(HBLANK_END + HMOVE_EXT);
    localparam logic [HCW-1:0] LAST_X        = HCW'(LINE_CLKS - 1);

    logic [HCW-1:0]     hcount_q, hcount_d;
    logic               extend_q, extend_d;
    logic [HMC_W-1:0]   hmc_q, hmc_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               sec_q, sec_d;
    logic               rdy_q, rdy_d;
    logic               hold_q, hold_d;
    line_dec_t          dec;

    // Position decodes from the registered counter.
    always_comb begin
        dec.line_start = (hcount_q == '0);
        dec.hsync      = ({1'b0, hcount_q} >= HSYNC_START_X) &&
                         ({1'b0, hcount_q} <  HSYNC_END_X);
        dec.hblank     = ({1'b0, hcount_q} < (extend_q ? BLANK_EXT_X : BLANK_X));
    end

    always_comb begin
        hcount_d = hcount_q + HCW'(1);
        if (hcount_q == LAST_X || rsyn_i) begin
            hcount_d = '0;
        end

        extend_d = extend_q;
        if (hmove_i) begin
            extend_d = 1'b1;
        end else if (dec.line_start) begin
            extend_d = 1'b0;
        end

        // Motion sequencer: reload on hmove, otherwise step down once every 4 clocks.
        hmc_d   = hmc_q;
        phase_d = phase_q;
        sec_d   = 1'b0;
        if (hmove_i) begin
            hmc_d   = HMC_W'(MOTION_STEPS);
            phase_d = '0;
        end else if (hmc_q != '0) begin
            if (phase_q == PHASE_W'(SEC_LAST)) begin
                hmc_d   = hmc_q - HMC_W'(1);
                phase_d = '0;
                sec_d   = 1'b1;
            end else begin
                phase_d = phase_q + PHASE_W'(1);
            end
        end

        // A halt issued together with rsyn must skip the line_start that rsyn itself creates.
        rdy_d  = rdy_q;
        hold_d = hold_q;
        if (rdy_q) begin
            if (wsyn_i) begin
                rdy_d  = 1'b0;
                hold_d = rsyn_i;
            end
        end else if (dec.line_start) begin
            if (hold_q) begin
                hold_d = 1'b0;
            end else begin
                rdy_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hcount_q <= '0;
            extend_q <= 1'b0;
            hmc_q    <= '0;
            phase_q  <= '0;
            sec_q    <= 1'b0;
            rdy_q    <= 1'b1;
            hold_q   <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            extend_q <= extend_d;
            hmc_q    <= hmc_d;
            phase_q  <= phase_d;
            sec_q    <= sec_d;
            rdy_q    <= rdy_d;
            hold_q   <= hold_d;
        end
    end

    tia_divide_by_n #(
        .N (CPU_DIV)
    ) u_cpu_div (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .out_o   (phi_theta_o)
    );

    assign hcount_o      = hcount_q;
    assign line_start_o  = dec.line_start;
    assign hsync_o       = dec.hsync;
    assign syn_o         = dec.hsync | vsyn_i;
    assign blank_o       = dec.hblank | vblk_i;
    assign motck_en_o    = ~dec.hblank;
    assign hmove_count_o = hmc_q;
    assign sec_o         = sec_q;
    assign rdy_o         = rdy_q;

endmodule

// File: tb/tb_tia_line_timing_generator.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a negedge monitor retires them.
module tb_tia_line_timing_generator;

    localparam int S_HC = 0, S_LS = 1, S_HS = 2, S_SYN = 3, S_BLK = 4, S_MOT = 5,
                   S_HMC = 6, S_SEC = 7, S_RDY = 8, S_PHI = 9, B = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       a_reset, a_wsyn, a_rsyn, a_hmove, a_vsyn, a_vblk;
    logic [7:0] a_hcount;
    logic [3:0] a_hmc;
    logic       a_ls, a_hsync, a_syn, a_blank, a_mot, a_sec, a_rdy, a_phi;

    logic       b_reset, b_wsyn, b_rsyn, b_hmove, b_vsyn, b_vblk;
    logic [7:0] b_hcount;
    logic [3:0] b_hmc;
    logic       b_ls, b_hsync, b_syn, b_blank, b_mot, b_sec, b_rdy, b_phi;

    tia_line_timing_generator u_dut_a (
        .clk_i(clk), .reset_i(a_reset), .wsyn_i(a_wsyn), .rsyn_i(a_rsyn), .hmove_i(a_hmove),
        .vsyn_i(a_vsyn), .vblk_i(a_vblk), .hcount_o(a_hcount), .line_start_o(a_ls),
        .hsync_o(a_hsync), .syn_o(a_syn), .blank_o(a_blank), .motck_en_o(a_mot),
        .hmove_count_o(a_hmc), .sec_o(a_sec), .rdy_o(a_rdy), .phi_theta_o(a_phi)
    );

    tia_line_timing_generator #(.LINE_CLKS(160), .CPU_DIV(4)) u_dut_b (
        .clk_i(clk), .reset_i(b_reset), .wsyn_i(b_wsyn), .rsyn_i(b_rsyn), .hmove_i(b_hmove),
        .vsyn_i(b_vsyn), .vblk_i(b_vblk), .hcount_o(b_hcount), .line_start_o(b_ls),
        .hsync_o(b_hsync), .syn_o(b_syn), .blank_o(b_blank), .motck_en_o(b_mot),
        .hmove_count_o(b_hmc), .sec_o(b_sec), .rdy_o(b_rdy), .phi_theta_o(b_phi)
    );

    typedef struct {
        int unsigned at;
        int          sid;
        int unsigned val;
        string       nm;
    } chk_t;

    chk_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] obs(input int sid);
        logic [31:0] r;
        r = 'x;
        case (sid)
            S_HC:      r = 32'(a_hcount);
            S_LS:      r = 32'(a_ls);
            S_HS:      r = 32'(a_hsync);
            S_SYN:     r = 32'(a_syn);
            S_BLK:     r = 32'(a_blank);
            S_MOT:     r = 32'(a_mot);
            S_HMC:     r = 32'(a_hmc);
            S_SEC:     r = 32'(a_sec);
            S_RDY:     r = 32'(a_rdy);
            S_PHI:     r = 32'(a_phi);
            B + S_HC:  r = 32'(b_hcount);
            B + S_LS:  r = 32'(b_ls);
            B + S_BLK: r = 32'(b_blank);
            B + S_MOT: r = 32'(b_mot);
            B + S_HMC: r = 32'(b_hmc);
            B + S_SEC: r = 32'(b_sec);
            B + S_RDY: r = 32'(b_rdy);
            B + S_PHI: r = 32'(b_phi);
            default:   r = 'x;
        endcase
        return r;
    endfunction

    task automatic exp(input int unsigned at, input int sid, input int unsigned v, input string nm);
        chk_t c;
        c.at  = at;
        c.sid = sid;
        c.val = v;
        c.nm  = nm;
        sb.push_back(c);
    endtask

    task automatic goto(input int unsigned c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: retire every expectation stamped for the current cycle.
    always @(negedge clk) begin
        logic [31:0] got;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                got = obs(sb[i].sid);
                n_cmp++;
                if (got !== 32'(sb[i].val)) begin
                    n_bad++;
                    $display("FAIL %s @cyc %0d: got %0d expected %0d", sb[i].nm, cyc, got, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    // Default-parameter DUT: line bases at cyc 2, 230, 458, 686, 914.
    initial begin
        a_reset = 1'b1; a_wsyn = 1'b0; a_rsyn = 1'b0; a_hmove = 1'b0; a_vsyn = 1'b0; a_vblk = 1'b0;
        exp(2, S_HC, 0, "a_rst_hcount");   exp(2, S_LS, 1, "a_rst_line_start");
        exp(2, S_HMC, 0, "a_rst_hmc");     exp(2, S_PHI, 0, "a_rst_phi");
        exp(2, S_RDY, 1, "a_rst_rdy");     exp(2, S_SEC, 0, "a_rst_sec");
        exp(2, S_BLK, 1, "a_rst_blank");
        goto(2);
        a_reset = 1'b0;
        exp(21, S_HS, 0, "a_hsync_h19");   exp(22, S_HS, 1, "a_hsync_h20");
        exp(37, S_HS, 1, "a_hsync_h35");   exp(38, S_HS, 0, "a_hsync_h36");
        exp(22, S_SYN, 1, "a_syn_h20");    exp(38, S_SYN, 0, "a_syn_h36");
        exp(69, S_BLK, 1, "a_blank_h67");  exp(70, S_BLK, 0, "a_blank_h68");
        exp(69, S_MOT, 0, "a_motck_h67");  exp(70, S_MOT, 1, "a_motck_h68");
        exp(229, S_HC, 227, "a_hc_h227");  exp(229, S_LS, 0, "a_ls_h227");
        exp(230, S_HC, 0, "a_hc_wrap");    exp(230, S_LS, 1, "a_ls_wrap");
        exp(3, S_PHI, 0, "a_phi_c3");      exp(4, S_PHI, 0, "a_phi_c4");
        exp(5, S_PHI, 1, "a_phi_c5");      exp(6, S_PHI, 0, "a_phi_c6");
        exp(7, S_PHI, 0, "a_phi_c7");      exp(8, S_PHI, 1, "a_phi_c8");

        goto(330); a_wsyn = 1'b1;
        exp(330, S_RDY, 1, "wsyn_rdy_h100"); exp(331, S_RDY, 0, "wsyn_rdy_h101");
        exp(457, S_RDY, 0, "wsyn_rdy_h227"); exp(458, S_RDY, 0, "wsyn_rdy_h0");
        exp(459, S_RDY, 1, "wsyn_rdy_h1");
        goto(331); a_wsyn = 1'b0;

        goto(430); a_vblk = 1'b1; exp(430, S_BLK, 1, "vblk_blank");
        goto(431); a_vblk = 1'b0; exp(431, S_BLK, 0, "vblk_clear");
        goto(440); a_vsyn = 1'b1; exp(440, S_SYN, 1, "vsyn_syn"); exp(440, S_HS, 0, "vsyn_hsync");
        goto(441); a_vsyn = 1'b0; exp(441, S_SYN, 0, "vsyn_clear");

        goto(461); a_hmove = 1'b1;
        exp(461, S_HMC, 0, "hm_idle_h3");
        for (int h = 4; h <= 66; h++) begin
            exp(458 + h, S_HMC, 15 - (h - 4) / 4, "hm_count");
            exp(458 + h, S_SEC, (((h - 4) % 4 == 0) && (h >= 8)) ? 1 : 0, "hm_sec");
        end
        exp(533, S_BLK, 1, "hm_blank_h75"); exp(534, S_BLK, 0, "hm_blank_h76");
        exp(533, S_MOT, 0, "hm_motck_h75"); exp(534, S_MOT, 1, "hm_motck_h76");
        exp(753, S_BLK, 1, "hm_next_h67");  exp(754, S_BLK, 0, "hm_next_h68");
        goto(462); a_hmove = 1'b0;

        goto(786); a_hmove = 1'b1;
        exp(787, S_HMC, 15, "rl_load");  exp(791, S_HMC, 14, "rl_step1");
        exp(795, S_HMC, 13, "rl_step2"); exp(796, S_HMC, 13, "rl_before");
        goto(787); a_hmove = 1'b0;
        goto(796); a_hmove = 1'b1;
        exp(797, S_HMC, 15, "rl_reload"); exp(800, S_HMC, 15, "rl_hold");
        exp(801, S_HMC, 14, "rl_first");  exp(801, S_SEC, 1, "rl_first_sec");
        exp(856, S_HMC, 1, "rl_last1");   exp(857, S_HMC, 0, "rl_done");
        exp(857, S_SEC, 1, "rl_done_sec"); exp(858, S_SEC, 0, "rl_idle_sec");
        goto(797); a_hmove = 1'b0;

        goto(1064); a_rsyn = 1'b1;
        exp(1064, S_HC, 150, "rsyn_h150");
        exp(1065, S_HC, 0, "rsyn_hc0");    exp(1065, S_LS, 1, "rsyn_ls");
        exp(1292, S_HC, 227, "rsyn_h227"); exp(1292, S_LS, 0, "rsyn_ls_off");
        exp(1293, S_HC, 0, "rsyn_wrap");   exp(1293, S_LS, 1, "rsyn_wrap_ls");
        exp(1066, S_PHI, 0, "rsyn_phi_a"); exp(1067, S_PHI, 1, "rsyn_phi_b");
        goto(1065); a_rsyn = 1'b0;

        goto(1343); a_wsyn = 1'b1; a_rsyn = 1'b1;
        exp(1344, S_HC, 0, "wr_hc0");    exp(1344, S_RDY, 0, "wr_rdy_ls1");
        exp(1345, S_RDY, 0, "wr_rdy_h1"); exp(1571, S_RDY, 0, "wr_rdy_h227");
        exp(1572, S_LS, 1, "wr_ls2");     exp(1572, S_RDY, 0, "wr_rdy_ls2");
        exp(1573, S_RDY, 1, "wr_release"); exp(1573, S_HC, 1, "wr_hc1");
        goto(1344); a_wsyn = 1'b0; a_rsyn = 1'b0;

        goto(1580);
        n_cmp++;
        if (a_hcount !== 8'd8) begin
            n_bad++;
            $display("FAIL a_final_hcount: got %0d expected 8", a_hcount);
        end
        n_cmp++;
        if (a_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL a_final_rdy: got %0d expected 1", a_rdy);
        end
        n_cmp++;
        if (a_hmc !== 4'd0) begin
            n_bad++;
            $display("FAIL a_final_hmc: got %0d expected 0", a_hmc);
        end
        while (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never sampled, expected %0d at cyc %0d", sb[0].nm, sb[0].val, sb[0].at);
            void'(sb.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // 160-clock line, CPU_DIV=4, reset asserted mid-HMOVE.
    initial begin
        b_reset = 1'b1; b_wsyn = 1'b0; b_rsyn = 1'b0; b_hmove = 1'b0; b_vsyn = 1'b0; b_vblk = 1'b0;
        exp(2, B + S_HC, 0, "b_rst_hcount"); exp(2, B + S_PHI, 0, "b_rst_phi");
        goto(2);
        b_reset = 1'b0;
        exp(3, B + S_PHI, 1, "b_phi_c3");  exp(4, B + S_PHI, 0, "b_phi_c4");
        exp(5, B + S_PHI, 0, "b_phi_c5");  exp(6, B + S_PHI, 1, "b_phi_c6");
        exp(7, B + S_PHI, 1, "b_phi_c7");  exp(8, B + S_PHI, 0, "b_phi_c8");
        exp(9, B + S_PHI, 0, "b_phi_c9");  exp(10, B + S_PHI, 1, "b_phi_c10");
        exp(161, B + S_HC, 159, "b_hc_h159"); exp(162, B + S_HC, 0, "b_hc_wrap");
        exp(162, B + S_LS, 1, "b_ls_wrap");

        goto(165); b_hmove = 1'b1;
        exp(166, B + S_HMC, 15, "b_hm_load"); exp(169, B + S_HMC, 15, "b_hm_hold");
        exp(170, B + S_HMC, 14, "b_hm_step"); exp(170, B + S_SEC, 1, "b_hm_sec");
        exp(182, B + S_HMC, 11, "b_hm_mid");  exp(182, B + S_BLK, 1, "b_hm_blank");
        goto(166); b_hmove = 1'b0;

        goto(172); b_wsyn = 1'b1;
        exp(173, B + S_RDY, 0, "b_wsyn_rdy");
        goto(173); b_wsyn = 1'b0;

        goto(182); b_reset = 1'b1;
        exp(183, B + S_HC, 0, "b_rr_hcount"); exp(183, B + S_LS, 1, "b_rr_ls");
        exp(183, B + S_HMC, 0, "b_rr_hmc");   exp(183, B + S_SEC, 0, "b_rr_sec");
        exp(183, B + S_PHI, 0, "b_rr_phi");   exp(183, B + S_RDY, 1, "b_rr_rdy");
        goto(183); b_reset = 1'b0;
        exp(184, B + S_HC, 1, "b_post_hc1");  exp(184, B + S_PHI, 1, "b_post_phi");
        exp(250, B + S_BLK, 1, "b_post_h67"); exp(251, B + S_BLK, 0, "b_post_h68");
        exp(251, B + S_MOT, 1, "b_post_motck"); exp(251, B + S_HC, 68, "b_post_hc68");
        goto(184);
        n_cmp++;
        if (b_hcount !== 8'd1) begin
            n_bad++;
            $display("FAIL b_direct_hc1: got %0d expected 1", b_hcount);
        end
    end

endmodule
